// File: rtl/test_reg_wait_rwn.sv
// Avalon-MM test slave: scratch regs, ID, R/W counters, programmable wait states.
// Latency WCFG+1 cycles per transfer; stalls via waitrequest, zero dead cycles between transfers.
module test_reg_wait_rwn #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 6,
    parameter int          NREG     = 8,
    parameter int          WAIT_W   = 5,
    parameter int          WAIT_RST = 4,
    parameter logic [31:0] ID_VALUE = 32'h5457_0001
) (
    input  logic                csi_MCLK_clk,
    input  logic                rsi_MRST_reset,
    input  logic [ADDR_W-1:0]   avs_test_address,
    input  logic [DATA_W-1:0]   avs_test_writedata,
    input  logic [DATA_W/8-1:0] avs_test_byteenable,
    input  logic                avs_test_write,
    input  logic                avs_test_read,
    output logic [DATA_W-1:0]   avs_test_readdata,
    output logic                avs_test_waitrequest
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [ADDR_W-1:0] A_ID   = {ADDR_W{1'b1}} - ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_WCNT = {ADDR_W{1'b1}} - ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_RCNT = {ADDR_W{1'b1}} - ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_WCFG = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   NREG_A = (ADDR_W+1)'(NREG);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wcfg_q, wcfg_d;
    logic [DATA_W-1:0]   wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   rcnt_q, rcnt_d;
    logic [DATA_W-1:0]   scr_q [NREG];
    logic [DATA_W-1:0]   scr_d [NREG];

    logic                req;
    logic                wr_only;
    logic                done;
    logic                is_scr;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   rd_word;

    assign req     = avs_test_read | avs_test_write;
    assign wr_only = avs_test_write & ~avs_test_read;
    assign is_scr  = {1'b0, avs_test_address} < NREG_A;
    assign idx     = avs_test_address[IDX_W-1:0];

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        done                 = 1'b0;
        avs_test_waitrequest = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (wcfg_q == '0) begin
                        done = 1'b1;
                    end else begin
                        avs_test_waitrequest = 1'b1;
                        cnt_d                = wcfg_q - WAIT_W'(1);
                        state_d              = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A dropped request abandons the transfer without side effects.
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    avs_test_waitrequest = 1'b1;
                    cnt_d                = cnt_q - WAIT_W'(1);
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        if (is_scr) begin
            rd_word = scr_q[idx];
        end else begin
            case (avs_test_address)
                A_ID:    rd_word = DATA_W'(ID_VALUE);
                A_WCNT:  rd_word = wcnt_q;
                A_RCNT:  rd_word = rcnt_q;
                A_WCFG:  rd_word = DATA_W'(wcfg_q);
                default: rd_word = '0;
            endcase
        end
        avs_test_readdata = (done && avs_test_read) ? rd_word : '0;
    end

    always_comb begin
        scr_d  = scr_q;
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        wcfg_d = wcfg_q;
        if (done && avs_test_read) begin
            rcnt_d = rcnt_q + DATA_W'(1);
        end
        if (done && wr_only) begin
            wcnt_d = wcnt_q + DATA_W'(1);
            if (is_scr) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (avs_test_byteenable[b]) begin
                        scr_d[idx][8*b +: 8] = avs_test_writedata[8*b +: 8];
                    end
                end
            end else begin
                // Clearing WCNT wins over its own completion increment.
                case (avs_test_address)
                    A_WCNT:  wcnt_d = '0;
                    A_RCNT:  rcnt_d = '0;
                    A_WCFG:  wcfg_d = avs_test_writedata[WAIT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wcfg_q  <= WAIT_W'(WAIT_RST);
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                scr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcfg_q  <= wcfg_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            scr_q   <= scr_d;
        end
    end
endmodule

// File: doc/test_reg_wait_rwn.md
# test_reg_wait_rwn

Parametrised Avalon-MM test slave with a scratch register file and programmable wait states. It succeeds the fixed 8-bit test register block. Width, register count and wait-state count are configurable. It adds byte enables, per-direction transaction counters and an ID word. It sits on the MCU-facing Avalon bus and is used to exercise master waitrequest handling and bus integrity.

## Interface
Parameters:
- DATA_W, 32, data width; multiple of 8
- ADDR_W, 6, word address width
- NREG, 8, scratch registers; NREG ≤ 2^ADDR_W − 4
- WAIT_W, 5, width of the wait-state config field
- WAIT_RST, 4, reset value of the wait-state config
- ID_VALUE, 32'h5457_0001, constant returned by the ID word (truncated to DATA_W)

Ports:
- csi_MCLK_clk  in  1  system clock; the block has one clock
- rsi_MRST_reset  in  1  reset, synchronous and active-high
- avs_test_address  in  ADDR_W  word address
- avs_test_writedata  in  DATA_W  write data
- avs_test_byteenable  in  DATA_W/8  write byte lanes; reads ignore it
- avs_test_write  in  1  write request
- avs_test_read  in  1  read request
- avs_test_readdata  out  DATA_W  read data; valid only when read=1 and waitrequest=0
- avs_test_waitrequest  out  1  stall

## Operation
Address map (T = 2^ADDR_W):
- 0..NREG−1: scratch, R/W, byte-enabled; reset 0
- T−4: ID, read-only, returns ID_VALUE
- T−3: WCNT, completed-write counter, DATA_W bits, wraps; any write clears it
- T−2: RCNT, completed-read counter, DATA_W bits, wraps; any write clears it
- T−1: WCFG, low WAIT_W bits R/W; reads zero-extended; reset WAIT_RST
- All other addresses: read 0; writes ignored, but still counted and still stalled

Request and priority:
- A request is read|write.
- If read and write are both high, the cycle is a read and the write is discarded.

FSM (registered state, cnt WAIT_W bits):
- IDLE, request present, WCFG=0: transfer completes this cycle; stay IDLE.
- IDLE, request present, WCFG≠0: cnt←WCFG−1; go to WAIT.
- WAIT, request still present, cnt≠0: cnt←cnt−1.
- WAIT, request still present, cnt=0: transfer completes this cycle; go to IDLE.
- WAIT, request dropped (protocol violation): go to IDLE; no register effect; no count.

waitrequest (combinational):
- (IDLE & request & WCFG≠0) | (WAIT & request & cnt≠0)

Completion, on the clock edge of the completion cycle:
- Write: the write action is taken.
- Read: RCNT increments.
- Write: WCNT increments unless the write targets that same counter; clear has priority, giving 0.

readdata:
- In a read completion cycle: combinational mux of the addressed word, pre-update values. A read of RCNT returns the count before its own increment.
- In all other cycles: 0.

WCFG update:
- A WCFG write affects the next transfer, not the current one.
- A transfer already in WAIT finishes with its loaded cnt.

## Timing
- Every transfer takes WCFG+1 cycles, of which WCFG cycles have waitrequest=1.
- Back-to-back transfers are allowed. A new request may be issued in the cycle after completion; the FSM returns to IDLE with zero dead cycles.
- Reset (synchronous, rsi_MRST_reset=1 at an edge):
  - state=IDLE, cnt=0
  - scratch=0, counters=0, WCFG=WAIT_RST
- Outputs during reset: waitrequest follows its equation with WCFG=WAIT_RST. Requests present during reset cycles have no effect.
- Reset asserted mid-WAIT aborts the transfer; nothing is written or counted.
- Counters wrap from 2^DATA_W−1 to 0.

## Test plan
- Reset, then read ID with WCFG=4: waitrequest high for exactly 4 cycles, then readdata=ID_VALUE for 1 cycle. A following read of RCNT returns 1.
- Write WCFG=0; write 0xA5A5_5A5A to addr 2; read addr 2: each transfer completes in 1 cycle with waitrequest never high, and readdata=0xA5A5_5A5A.
- Write 0xFFFF_FFFF to addr 1 with byteenable=4'b0101 over the prior value 0: readback is 0x00FF_00FF.
- WCFG=3, then read and write asserted together to addr 0 with writedata 0x1234: this is a read (3 wait cycles). Addr 0 is unchanged, RCNT+1, WCNT unchanged.
- WCFG=6; after 2 wait cycles the master drops read: FSM returns to IDLE, RCNT unchanged. The next read shows the full 6 wait cycles.
- Write to WCNT: WCNT=0, not 1. Preload-free wrap check with DATA_W=8: 256 writes to addr 0 leave WCNT=0. Reset asserted mid-WAIT of a write leaves the target register unwritten.
